// File: rtl/issue_pair_ctrl_if.sv
// Decode-to-EX bundle for the dual-issue stage.
//   slave  : issue-stage view. Decoded pair (id_*) and ex_ready come in;
//            id_ready, registered EX lane fields (ex_*) and hazard codes go out.
//   master : decode/EX-side view, the mirror image of slave.
// Lane A is the older instruction of the pair, lane B the younger.
interface issue_pair_ctrl_if #(
  parameter int unsigned PAYLOAD_W = 64
);
  logic                 id_valid;
  logic                 id_ready;
  logic                 id_b_valid;
  logic [3:0]           id_a_type, id_b_type;
  logic [4:0]           id_a_rd, id_a_rs1, id_a_rs2;
  logic [4:0]           id_b_rd, id_b_rs1, id_b_rs2;
  logic                 id_a_reg_write, id_b_reg_write;
  logic [PAYLOAD_W-1:0] id_a_payload, id_b_payload;
  logic                 ex_ready;
  logic                 ex_a_valid, ex_b_valid;
  logic [3:0]           ex_a_type, ex_b_type;
  logic [4:0]           ex_a_rd, ex_b_rd;
  logic                 ex_a_reg_write, ex_b_reg_write;
  logic [PAYLOAD_W-1:0] ex_a_payload, ex_b_payload;
  logic [3:0]           haz_a, haz_b;

  modport slave (
    input  id_valid, id_b_valid, id_a_type, id_b_type,
    input  id_a_rd, id_a_rs1, id_a_rs2, id_b_rd, id_b_rs1, id_b_rs2,
    input  id_a_reg_write, id_b_reg_write, id_a_payload, id_b_payload,
    input  ex_ready,
    output id_ready,
    output ex_a_valid, ex_b_valid, ex_a_type, ex_b_type, ex_a_rd, ex_b_rd,
    output ex_a_reg_write, ex_b_reg_write, ex_a_payload, ex_b_payload,
    output haz_a, haz_b
  );

  modport master (
    output id_valid, id_b_valid, id_a_type, id_b_type,
    output id_a_rd, id_a_rs1, id_a_rs2, id_b_rd, id_b_rs1, id_b_rs2,
    output id_a_reg_write, id_b_reg_write, id_a_payload, id_b_payload,
    output ex_ready,
    input  id_ready,
    input  ex_a_valid, ex_b_valid, ex_a_type, ex_b_type, ex_a_rd, ex_b_rd,
    input  ex_a_reg_write, ex_b_reg_write, ex_a_payload, ex_b_payload,
    input  haz_a, haz_b
  );
endinterface

// File: rtl/issue_pair_ctrl.sv
// Dual-issue stage between decode and the two EX lanes.
// Detects intra-pair RAW and load-use hazards, inserts bubbles or splits the
// pair, and drives registered EX lane inputs plus per-lane hazard codes.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : issue_pair_ctrl_if.slave (decode pair in, EX lanes out)
module issue_pair_ctrl #(
  parameter int unsigned PAYLOAD_W        = 64,
  parameter int unsigned LOAD_USE_BUBBLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  issue_pair_ctrl_if.slave bus
);
  typedef enum logic [3:0] {
    R_TYPE_i = 4'd0, I_IMM_i = 4'd1, LOAD_i  = 4'd2, S_TYPE_i = 4'd3,
    B_TYPE_i = 4'd4, JAL_i   = 4'd5, JALR_i  = 4'd6, LUI_i    = 4'd7,
    AUIPC_i  = 4'd8, ECALL_i = 4'd9, NOP_i   = 4'd10, NONE_i  = 4'd11
  } itype_e;

  typedef enum logic [3:0] {
    A_STALL     = 4'd0, B_STALL = 4'd1, STALL_FROM_A = 4'd2, STALL_FROM_B = 4'd3,
    FORW_FROM_A = 4'd8, HOLD_B  = 4'd9, B_INVALID    = 4'd10, NONE_h      = 4'd11
  } haz_e;

  typedef enum logic [1:0] {PAIR, STALL, HOLD} state_e;

  typedef struct packed {
    logic                 valid;
    logic [3:0]           typ;
    logic [4:0]           rd;
    logic                 rw;
    logic [PAYLOAD_W-1:0] payload;
  } lane_t;

  typedef struct packed {
    logic [3:0]           typ;
    logic [4:0]           rd, rs1, rs2;
    logic                 rw;
    logic [PAYLOAD_W-1:0] payload;
  } held_t;

  localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_BUBBLES - 1);

  state_e state, state_nx;
  logic [1:0] cnt, cnt_nx;
  held_t hold, id_b_held;
  lane_t lane_a, lane_b, lane_a_nx, lane_b_nx, id_a_lane, id_b_lane;
  haz_e haz_a_q, haz_b_q, haz_a_nx, haz_b_nx;
  logic lu_a, lu_b, lu_h, raw, hold_load;

  function automatic logic reads(input logic [3:0] t, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] r);
    logic use1, use2;
    use1 = !(t inside {JAL_i, LUI_i, AUIPC_i, ECALL_i, NOP_i, NONE_i});
    use2 = t inside {R_TYPE_i, S_TYPE_i, B_TYPE_i};
    return (use1 && rs1 != '0 && rs1 == r) || (use2 && rs2 != '0 && rs2 == r);
  endfunction

  // Candidate reads the destination of a load currently sitting in an EX lane.
  function automatic logic load_use(input logic [3:0] t, input logic [4:0] rs1,
                                    input logic [4:0] rs2);
    logic hit_a, hit_b;
    hit_a = lane_a.valid && lane_a.typ == LOAD_i && lane_a.rw && lane_a.rd != '0
            && reads(t, rs1, rs2, lane_a.rd);
    hit_b = lane_b.valid && lane_b.typ == LOAD_i && lane_b.rw && lane_b.rd != '0
            && reads(t, rs1, rs2, lane_b.rd);
    return hit_a || hit_b;
  endfunction

  assign id_a_lane = '{valid: 1'b1, typ: bus.id_a_type, rd: bus.id_a_rd,
                       rw: bus.id_a_reg_write, payload: bus.id_a_payload};
  assign id_b_lane = '{valid: bus.id_b_valid, typ: bus.id_b_type, rd: bus.id_b_rd,
                       rw: bus.id_b_reg_write, payload: bus.id_b_payload};
  assign id_b_held = '{typ: bus.id_b_type, rd: bus.id_b_rd, rs1: bus.id_b_rs1,
                       rs2: bus.id_b_rs2, rw: bus.id_b_reg_write, payload: bus.id_b_payload};

  always_comb begin
    lu_a = load_use(bus.id_a_type, bus.id_a_rs1, bus.id_a_rs2);
    lu_b = bus.id_b_valid && load_use(bus.id_b_type, bus.id_b_rs1, bus.id_b_rs2);
    lu_h = load_use(hold.typ, hold.rs1, hold.rs2);
    raw  = bus.id_b_valid && bus.id_a_reg_write && bus.id_a_rd != '0
           && reads(bus.id_b_type, bus.id_b_rs1, bus.id_b_rs2, bus.id_a_rd);
  end

  assign bus.id_ready = bus.ex_ready && state == PAIR && !(lu_a || lu_b);

  // State register; ex_ready low freezes every flop including the EX lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PAIR;
      cnt     <= '0;
      hold    <= '0;
      lane_a  <= '0;
      lane_b  <= '0;
      haz_a_q <= NONE_h;
      haz_b_q <= NONE_h;
    end else if (bus.ex_ready) begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      lane_a  <= lane_a_nx;
      lane_b  <= lane_b_nx;
      haz_a_q <= haz_a_nx;
      haz_b_q <= haz_b_nx;
      if (hold_load) hold <= id_b_held;
    end
  end

  // Next state. The PAIR-state bubble is the first of the load-use bubbles,
  // so STALL/HOLD only count the remaining LOAD_USE_BUBBLES-1.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    hold_load = 1'b0;
    case (state)
      PAIR: begin
        if (bus.id_valid) begin
          if (lu_a || lu_b) begin
            if (CNT_INIT != '0) begin
              state_nx = STALL;
              cnt_nx   = CNT_INIT;
            end
          end else if (raw) begin
            state_nx  = HOLD;
            hold_load = 1'b1;
          end
        end
      end
      STALL: begin
        if (cnt <= 2'd1) begin
          state_nx = PAIR;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 2'd1;
        end
      end
      HOLD: begin
        if (cnt != '0)  cnt_nx   = cnt - 2'd1;
        else if (lu_h)  cnt_nx   = CNT_INIT;
        else            state_nx = PAIR;
      end
      default: state_nx = PAIR;
    endcase
  end

  // Next EX lane contents and hazard codes; bubbles keep fields, drop valids.
  always_comb begin
    lane_a_nx       = lane_a;
    lane_a_nx.valid = 1'b0;
    lane_b_nx       = lane_b;
    lane_b_nx.valid = 1'b0;
    haz_a_nx        = haz_a_q;
    haz_b_nx        = haz_b_q;
    case (state)
      PAIR: begin
        if (!bus.id_valid) begin
          haz_a_nx = NONE_h;
          haz_b_nx = NONE_h;
        end else if (lu_a || lu_b) begin
          if (lu_a) haz_a_nx = A_STALL;
          else      haz_a_nx = STALL_FROM_B;
          if (lu_b) haz_b_nx = B_STALL;
          else      haz_b_nx = STALL_FROM_A;
        end else begin
          lane_a_nx = id_a_lane;
          haz_a_nx  = NONE_h;
          if (raw) begin
            haz_b_nx = HOLD_B;
          end else begin
            lane_b_nx = id_b_lane;
            if (bus.id_b_valid) haz_b_nx = NONE_h;
            else                haz_b_nx = B_INVALID;
          end
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          if (lu_h) begin
            haz_a_nx = STALL_FROM_B;
            haz_b_nx = B_STALL;
          end else begin
            lane_b_nx = '{valid: 1'b1, typ: hold.typ, rd: hold.rd,
                          rw: hold.rw, payload: hold.payload};
            haz_a_nx  = NONE_h;
            haz_b_nx  = FORW_FROM_A;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.ex_a_valid     = lane_a.valid;
  assign bus.ex_a_type      = lane_a.typ;
  assign bus.ex_a_rd        = lane_a.rd;
  assign bus.ex_a_reg_write = lane_a.rw;
  assign bus.ex_a_payload   = lane_a.payload;
  assign bus.ex_b_valid     = lane_b.valid;
  assign bus.ex_b_type      = lane_b.typ;
  assign bus.ex_b_rd        = lane_b.rd;
  assign bus.ex_b_reg_write = lane_b.rw;
  assign bus.ex_b_payload   = lane_b.payload;
  assign bus.haz_a          = haz_a_q;
  assign bus.haz_b          = haz_b_q;
endmodule

// File: doc/issue_pair_ctrl.md
Name: issue_pair_ctrl

Overview:
- Dual-issue stage that sits directly downstream of decode and directly upstream of the two EX lanes (A = older, B = younger).
- Accepts one decoded instruction pair per handshake.
- Detects intra-pair RAW hazards and load-use hazards, inserts bubbles or splits the pair, and drives registered EX-lane inputs.
- Reports 4-bit hazard codes per lane for waveform decode via the hazard enum helper.

Parameters:
- PAYLOAD_W, 64: width of the opaque per-lane payload (operands, immediates, ALU op) carried through unchanged.
- LOAD_USE_BUBBLES, 1: number of bubble cycles inserted on a load-use hazard; legal range 1..3.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode presents a pair.
- id_ready  out  1  stage accepts the pair this cycle.
- id_b_valid  in  1  lane B slot holds a real instruction.
- id_a_type, id_b_type  in  4  instruction type (R_TYPE_i=0, I_IMM_i=1, LOAD_i=2, S_TYPE_i=3, B_TYPE_i=4, JAL_i=5, JALR_i=6, LUI_i=7, AUIPC_i=8, ECALL_i=9, NOP_i=10, NONE_i=11).
- id_a_rd/rs1/rs2, id_b_rd/rs1/rs2  in  5 each  register indices.
- id_a_reg_write, id_b_reg_write  in  1 each  instruction writes rd.
- id_a_payload, id_b_payload  in  PAYLOAD_W each  pass-through data.
- ex_ready  in  1  EX accepts new inputs this cycle.
- ex_a_valid, ex_b_valid  out  1 each  registered lane valids.
- ex_a_type, ex_b_type  out  4 each; ex_a_rd, ex_b_rd  out  5 each; ex_a_reg_write, ex_b_reg_write  out  1 each; ex_a_payload, ex_b_payload  out  PAYLOAD_W each  registered copies.
- haz_a, haz_b  out  4 each  registered hazard code (A_STALL=0, B_STALL=1, STALL_FROM_A=2, STALL_FROM_B=3, FORW_FROM_A=8, HOLD_B=9, B_INVALID=10, NONE_h=11).

Behaviour:
- Reset (async, rst_n=0): all ex_* valids, rd, type, reg_write and payload = 0; haz_a = haz_b = 4'hB; state = PAIR; bubble counter = 0; hold register cleared. Takes effect mid-operation with no drain.
- Source usage: rs1 is used by all types except JAL_i, LUI_i, AUIPC_i, ECALL_i, NOP_i, NONE_i. rs2 is used by R_TYPE_i, S_TYPE_i, B_TYPE_i. A source never hazards when its index = 0.
- Load-use: the candidate instruction reads rd of a valid EX-register lane with type LOAD_i, reg_write = 1 and rd != 0.
- Intra-pair RAW: id_b_valid, id_a_reg_write, id_a_rd != 0, and B uses a source equal to id_a_rd. Intra-pair WAW needs no action; B commits later.
- ex_ready = 0 freezes everything: outputs, state and counter hold, and id_ready = 0.
- id_ready = ex_ready & state == PAIR & no load-use on the presented pair.
- State PAIR, id_valid = 1:
  - Load-use on A or B: issue a bubble (both ex valids 0). haz_a = A_STALL if A depends, else STALL_FROM_B. haz_b = B_STALL if B depends, else STALL_FROM_A. Go to STALL with counter = LOAD_USE_BUBBLES-1, or remain PAIR and re-check when LOAD_USE_BUBBLES = 1.
  - Else intra-pair RAW: accept the pair and issue A only. haz_a = NONE_h, haz_b = HOLD_B. Copy B into the hold register and go to HOLD.
  - Else: issue both (B valid = id_b_valid). haz_a = NONE_h. haz_b = B_INVALID if !id_b_valid, else NONE_h.
- State PAIR, id_valid = 0: issue a bubble; both haz codes = NONE_h.
- State STALL: issue a bubble; haz codes keep their stall values. Decrement the counter each ex_ready cycle; at 0, return to PAIR.
- State HOLD:
  - Present the held B as candidate, on lane B only; ex_a_valid = 0.
  - If load-use (A was a load now in EX): issue a bubble, set haz_b = B_STALL and haz_a = STALL_FROM_B, and stay in HOLD for LOAD_USE_BUBBLES cycles via the counter.
  - Else: issue B with haz_b = FORW_FROM_A and haz_a = NONE_h, then go to PAIR.
- Latency: one cycle from handshake to ex_* outputs, or two cycles for held B with no load.
- Throughput: two instructions per cycle with no hazards.

Test Plan:
- Reset check: assert rst_n low mid-HOLD -> next sample ex_a_valid = ex_b_valid = 0, haz_a = haz_b = 4'hB, id_ready = 1 once ex_ready = 1.
- Independent pair: A = ADD x5←x1,x2; B = ADD x6←x3,x4 -> next cycle both valid, haz = 11/11, id_ready stays 1.
- Intra-pair RAW: A writes x5; B = SUB x7←x5,x1 -> cycle 1: A only with haz_b = 9; cycle 2: B only with haz_b = 8, id_ready = 0 during hold.
- Load-use, LOAD_USE_BUBBLES = 1: EX holds LOAD x8; new A reads x8 -> one bubble with haz_a = 0, haz_b = 2, then the pair issues. Repeat with 2 bubbles and verify the counter.
- Load A then dependent B in the same pair: A = LOAD x9, B reads x9 -> A issues (haz_b = 9), one bubble (haz_b = 1, haz_a = 3), then B issues.
- Backpressure and single-issue: hold ex_ready = 0 for 3 cycles mid-STALL -> outputs and counter frozen. Send id_b_valid = 0 -> ex_b_valid = 0, haz_b = 10; rd = x0 dependence -> no hazard.
